// File: rtl/id_stage.sv
// Decode stage: holds one fetched instruction and decodes the integer-ALU subset into one-hot op + operands.
// Latency: combinational decode; an instruction loaded at edge N is offered to EX during cycle N.
// Backpressure: stalls (allowin low, payload frozen) on RAW hazard against EX/MEM writers or when EX refuses.
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  input  logic [31:0] inst_pc,
  output logic        ds_allowin,
  input  logic        flush,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        ex_gr_we,
  input  logic [4:0]  ex_dest,
  input  logic        mem_gr_we,
  input  logic [4:0]  mem_dest,
  input  logic        es_allowin,
  output logic        ds_to_es_valid,
  output logic [11:0] es_alu_op,
  output logic [31:0] es_alu_src1,
  output logic [31:0] es_alu_src2,
  output logic [4:0]  es_dest,
  output logic        es_gr_we,
  output logic [31:0] es_pc,
  output logic        es_inst_invalid
);

  // Pipeline register holding the instruction under decode
  logic        ds_valid_q, ds_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;

  // Instruction fields
  logic [9:0]  op31_22;
  logic [1:0]  op21_20;
  logic [4:0]  op19_15;
  logic [4:0]  rd, rj, rk;
  logic [11:0] imm12;
  logic [19:0] si20;

  assign op31_22 = inst_q[31:22];
  assign op21_20 = inst_q[21:20];
  assign op19_15 = inst_q[19:15];
  assign rd      = inst_q[4:0];
  assign rj      = inst_q[9:5];
  assign rk      = inst_q[14:10];
  assign imm12   = inst_q[21:10];
  assign si20    = inst_q[24:5];

  // Opcode group qualifiers
  logic grp_3r, grp_shimm;
  assign grp_3r    = (op31_22 == 10'h000) && (op21_20 == 2'b01);
  assign grp_shimm = (op31_22 == 10'h001) && (op21_20 == 2'b00);

  // Three-register ops
  logic inst_add_w, inst_sub_w, inst_slt, inst_sltu, inst_nor, inst_and;
  logic inst_or, inst_xor, inst_sll_w, inst_srl_w, inst_sra_w;
  assign inst_add_w = grp_3r && (op19_15 == 5'h00);
  assign inst_sub_w = grp_3r && (op19_15 == 5'h02);
  assign inst_slt   = grp_3r && (op19_15 == 5'h04);
  assign inst_sltu  = grp_3r && (op19_15 == 5'h05);
  assign inst_nor   = grp_3r && (op19_15 == 5'h08);
  assign inst_and   = grp_3r && (op19_15 == 5'h09);
  assign inst_or    = grp_3r && (op19_15 == 5'h0A);
  assign inst_xor   = grp_3r && (op19_15 == 5'h0B);
  assign inst_sll_w = grp_3r && (op19_15 == 5'h0E);
  assign inst_srl_w = grp_3r && (op19_15 == 5'h0F);
  assign inst_sra_w = grp_3r && (op19_15 == 5'h10);

  // Shift-by-immediate ops
  logic inst_slli_w, inst_srli_w, inst_srai_w;
  assign inst_slli_w = grp_shimm && (op19_15 == 5'h01);
  assign inst_srli_w = grp_shimm && (op19_15 == 5'h09);
  assign inst_srai_w = grp_shimm && (op19_15 == 5'h11);

  // 12-bit immediate ops
  logic inst_slti, inst_sltui, inst_addi_w, inst_andi, inst_ori, inst_xori;
  assign inst_slti   = (op31_22 == 10'h008);
  assign inst_sltui  = (op31_22 == 10'h009);
  assign inst_addi_w = (op31_22 == 10'h00A);
  assign inst_andi   = (op31_22 == 10'h00D);
  assign inst_ori    = (op31_22 == 10'h00E);
  assign inst_xori   = (op31_22 == 10'h00F);

  // Upper-immediate load
  logic inst_lu12i_w;
  assign inst_lu12i_w = (inst_q[31:25] == 7'b0001010);

  // Operand-format classes
  logic is_3r, is_3r_shift, is_shimm, is_si12, is_ui12, inst_known;
  assign is_3r_shift = inst_sll_w | inst_srl_w | inst_sra_w;
  assign is_3r       = inst_add_w | inst_sub_w | inst_slt | inst_sltu | inst_nor |
                       inst_and | inst_or | inst_xor | is_3r_shift;
  assign is_shimm    = inst_slli_w | inst_srli_w | inst_srai_w;
  assign is_si12     = inst_slti | inst_sltui | inst_addi_w;
  assign is_ui12     = inst_andi | inst_ori | inst_xori;
  assign inst_known  = is_3r | is_shimm | is_si12 | is_ui12 | inst_lu12i_w;

  // One-hot ALU opcode; an unknown word yields all zeros
  logic [11:0] alu_op;
  assign alu_op[0]  = inst_add_w | inst_addi_w;
  assign alu_op[1]  = inst_sub_w;
  assign alu_op[2]  = inst_slt   | inst_slti;
  assign alu_op[3]  = inst_sltu  | inst_sltui;
  assign alu_op[4]  = inst_and   | inst_andi;
  assign alu_op[5]  = inst_nor;
  assign alu_op[6]  = inst_or    | inst_ori;
  assign alu_op[7]  = inst_xor   | inst_xori;
  assign alu_op[8]  = inst_sll_w | inst_slli_w;
  assign alu_op[9]  = inst_srl_w | inst_srli_w;
  assign alu_op[10] = inst_sra_w | inst_srai_w;
  assign alu_op[11] = inst_lu12i_w;

  // Register file addressing: port 2 only carries rk for three-register ops
  assign rf_raddr1 = rj;
  assign rf_raddr2 = is_3r ? rk : 5'd0;

  // Operand 1: register rj except for lu12i.w which adds to zero
  logic [31:0] alu_src1;
  assign alu_src1 = inst_lu12i_w ? 32'd0 : rf_rdata1;

  // Operand 2 selection; register shifts keep only the 5-bit amount because the ALU uses all of src2
  logic [31:0] alu_src2;
  always_comb begin
    alu_src2 = 32'd0;
    if (is_3r_shift) begin
      alu_src2 = {27'd0, rf_rdata2[4:0]};
    end else if (is_3r) begin
      alu_src2 = rf_rdata2;
    end else if (is_shimm) begin
      alu_src2 = {27'd0, rk};
    end else if (is_si12) begin
      alu_src2 = {{20{imm12[11]}}, imm12};
    end else if (is_ui12) begin
      alu_src2 = {20'd0, imm12};
    end else if (inst_lu12i_w) begin
      alu_src2 = {si20, 12'd0};
    end
  end

  // Read-after-write hazard: only sources the op actually reads, and never r0
  logic use_rj, use_rk;
  logic rj_busy, rk_busy, hazard;
  assign use_rj  = inst_known & ~inst_lu12i_w;
  assign use_rk  = is_3r;
  assign rj_busy = (rj != 5'd0) &&
                   ((ex_gr_we && (rj == ex_dest)) || (mem_gr_we && (rj == mem_dest)));
  assign rk_busy = (rk != 5'd0) &&
                   ((ex_gr_we && (rk == ex_dest)) || (mem_gr_we && (rk == mem_dest)));
  assign hazard  = ds_valid_q & ((use_rj & rj_busy) | (use_rk & rk_busy));

  // Handshake
  logic ds_ready_go;
  assign ds_ready_go    = ~hazard;
  assign ds_allowin     = ~ds_valid_q | (ds_ready_go & es_allowin);
  assign ds_to_es_valid = ds_valid_q & ds_ready_go;

  // Payload is zeroed when the stage is empty so EX never sees stale decode
  assign es_alu_op       = ds_valid_q ? alu_op : 12'd0;
  assign es_alu_src1     = ds_valid_q ? alu_src1 : 32'd0;
  assign es_alu_src2     = ds_valid_q ? alu_src2 : 32'd0;
  assign es_dest         = ds_valid_q ? rd : 5'd0;
  assign es_gr_we        = ds_valid_q & inst_known & (rd != 5'd0);
  assign es_pc           = ds_valid_q ? pc_q : 32'd0;
  assign es_inst_invalid = ds_valid_q & ~inst_known;

  // Next-state: flush drops the held and any incoming instruction; otherwise load when allowed
  always_comb begin
    ds_valid_d = ds_valid_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    if (flush) begin
      ds_valid_d = 1'b0;
    end else if (ds_allowin) begin
      ds_valid_d = inst_valid;
      if (inst_valid) begin
        inst_d = inst;
        pc_d   = inst_pc;
      end
    end
  end

  // Stage register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid_q <= 1'b0;
      inst_q     <= 32'd0;
      pc_q       <= 32'd0;
    end else begin
      ds_valid_q <= ds_valid_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios with literal expectations, then randomized traffic.
// Outputs are compared every negedge against an instruction-level model of the stage.
// Register file is a bench array read combinationally through the DUT's read addresses.
module tb_id_stage;

  logic        clk;
  logic        reset;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        ds_allowin;
  logic        flush;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        ex_gr_we;
  logic [4:0]  ex_dest;
  logic        mem_gr_we;
  logic [4:0]  mem_dest;
  logic        es_allowin;
  logic        ds_to_es_valid;
  logic [11:0] es_alu_op;
  logic [31:0] es_alu_src1, es_alu_src2;
  logic [4:0]  es_dest;
  logic        es_gr_we;
  logic [31:0] es_pc;
  logic        es_inst_invalid;

  logic [31:0] regs [32];
  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  id_stage dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .ds_allowin(ds_allowin), .flush(flush),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_gr_we(ex_gr_we), .ex_dest(ex_dest), .mem_gr_we(mem_gr_we), .mem_dest(mem_dest),
    .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid),
    .es_alu_op(es_alu_op), .es_alu_src1(es_alu_src1), .es_alu_src2(es_alu_src2),
    .es_dest(es_dest), .es_gr_we(es_gr_we), .es_pc(es_pc), .es_inst_invalid(es_inst_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction table: codes 0..10 are 3R, 11..13 shift-imm, 14..19 2RI12, 20 lu12i.w
  int r3_f [11]     = '{0, 2, 4, 5, 8, 9, 10, 11, 14, 15, 16};
  int si_f [3]      = '{1, 9, 17};
  int ri_f [6]      = '{8, 9, 10, 13, 14, 15};
  int code_bit [21] = '{0, 1, 2, 3, 5, 4, 6, 7, 8, 9, 10, 8, 9, 10, 2, 3, 0, 4, 6, 7, 11};

  function automatic int classify(input logic [31:0] w);
    if (w[31:22] == 10'h000 && w[21:20] == 2'b01)
      for (int i = 0; i < 11; i++) if (int'(w[19:15]) == r3_f[i]) return i;
    if (w[31:22] == 10'h001 && w[21:20] == 2'b00)
      for (int i = 0; i < 3; i++) if (int'(w[19:15]) == si_f[i]) return 11 + i;
    for (int i = 0; i < 6; i++) if (int'(w[31:22]) == ri_f[i]) return 14 + i;
    if (w[31:25] == 7'b0001010) return 20;
    return -1;
  endfunction

  // Model state: the one instruction the stage should be holding
  logic        mv = 1'b0;
  logic [31:0] minst = 32'd0;
  logic [31:0] mpc = 32'd0;

  function automatic logic busy(input logic [4:0] r);
    return (r != 0) && ((ex_gr_we && r == ex_dest) || (mem_gr_we && r == mem_dest));
  endfunction

  function automatic logic m_hazard();
    int c;
    c = classify(minst);
    if (!mv || c < 0) return 1'b0;
    return (c != 20 && busy(minst[9:5])) || (c <= 10 && busy(minst[14:10]));
  endfunction

  // Model update on each rising edge
  always @(posedge clk) begin
    if (reset) begin
      mv <= 1'b0; minst <= 32'd0; mpc <= 32'd0;
    end else if (flush) begin
      mv <= 1'b0;
    end else if (!mv || (!m_hazard() && es_allowin)) begin
      mv <= inst_valid;
      if (inst_valid) begin
        minst <= inst; mpc <= inst_pc;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    int c;
    logic [4:0] rj, rk, rd;
    logic haz;
    logic [31:0] e2;
    if (chk_en) begin
      c   = classify(minst);
      rd  = minst[4:0];
      rj  = minst[9:5];
      rk  = minst[14:10];
      haz = m_hazard();
      chk("ds_to_es_valid", 32'(ds_to_es_valid), 32'(mv && !haz));
      chk("ds_allowin", 32'(ds_allowin), 32'(!mv || (!haz && es_allowin)));
      chk("rf_raddr1", 32'(rf_raddr1), 32'(rj));
      chk("rf_raddr2", 32'(rf_raddr2), (c >= 0 && c <= 10) ? 32'(rk) : 32'd0);
      if (!mv) begin
        chk("idle alu_op", 32'(es_alu_op), 32'd0);
        chk("idle src1", es_alu_src1, 32'd0);
        chk("idle src2", es_alu_src2, 32'd0);
        chk("idle dest", 32'(es_dest), 32'd0);
        chk("idle gr_we", 32'(es_gr_we), 32'd0);
        chk("idle pc", es_pc, 32'd0);
        chk("idle invalid", 32'(es_inst_invalid), 32'd0);
      end else begin
        chk("alu_op", 32'(es_alu_op), (c < 0) ? 32'd0 : (32'd1 << code_bit[c]));
        chk("invalid", 32'(es_inst_invalid), 32'(c < 0));
        chk("gr_we", 32'(es_gr_we), 32'(c >= 0 && rd != 0));
        chk("dest", 32'(es_dest), 32'(rd));
        chk("pc", es_pc, mpc);
        if (c >= 0) begin
          chk("src1", es_alu_src1, (c == 20) ? 32'd0 : regs[rj]);
          if (c <= 7)       e2 = regs[rk];
          else if (c <= 10) e2 = regs[rk] % 32;
          else if (c <= 13) e2 = 32'(rk);
          else if (c <= 16) e2 = 32'($signed(minst[21:10]));
          else if (c <= 19) e2 = 32'(minst[21:10]);
          else              e2 = {minst[24:5], 12'd0};
          chk("src2", es_alu_src2, e2);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single load edge, then leave the fetch side idle
  task automatic issue(input logic [31:0] w, input logic [31:0] pc);
    step();
    inst_valid = 1'b1; inst = w; inst_pc = pc;
    step();
    inst_valid = 1'b0;
  endtask

  function automatic logic [31:0] gen_inst();
    int c;
    logic [4:0] rj, rk, rd;
    c  = $urandom_range(0, 21);
    rj = 5'($urandom_range(0, 7));
    rk = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    if (c <= 10) return {10'h000, 2'b01, 5'(r3_f[c]), rk, rj, rd};
    if (c <= 13) return {10'h001, 2'b00, 5'(si_f[c - 11]), rk, rj, rd};
    if (c <= 19) return {10'(ri_f[c - 14]), 12'($urandom), rj, rd};
    if (c == 20) return {7'b0001010, 20'($urandom), rd};
    return $urandom;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    reset = 1'b1; inst_valid = 1'b0; inst = 32'd0; inst_pc = 32'd0; flush = 1'b0;
    ex_gr_we = 1'b0; ex_dest = 5'd0; mem_gr_we = 1'b0; mem_dest = 5'd0; es_allowin = 1'b1;

    // Reset held for two cycles
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset to_es", 32'(ds_to_es_valid), 32'd0);
    chk("reset allowin", 32'(ds_allowin), 32'd1);
    chk("reset alu_op", 32'(es_alu_op), 32'd0);
    chk("reset pc", es_pc, 32'd0);
    step();
    reset = 1'b0;

    // addi.w r4,r5,-1
    regs[5] = 32'h10;
    issue(32'h02BFFCA4, 32'h1C000000);
    @(negedge clk);
    chk("addi raddr1", 32'(rf_raddr1), 32'd5);
    chk("addi op", 32'(es_alu_op), 32'h001);
    chk("addi src1", es_alu_src1, 32'h10);
    chk("addi src2", es_alu_src2, 32'hFFFFFFFF);
    chk("addi dest", 32'(es_dest), 32'd4);
    chk("addi we", 32'(es_gr_we), 32'd1);
    chk("addi valid", 32'(ds_to_es_valid), 32'd1);
    chk("addi pc", es_pc, 32'h1C000000);

    // lu12i.w r1,0x12345 with an r0 writer in EX: no stall
    ex_gr_we = 1'b1; ex_dest = 5'd0;
    issue(32'h142468A1, 32'h1C000004);
    @(negedge clk);
    chk("lu12i op", 32'(es_alu_op), 32'h800);
    chk("lu12i src1", es_alu_src1, 32'd0);
    chk("lu12i src2", es_alu_src2, 32'h12345000);
    chk("lu12i dest", 32'(es_dest), 32'd1);
    chk("lu12i valid", 32'(ds_to_es_valid), 32'd1);

    // sll.w r6,r5,r7 stalled 3 cycles on r5 in EX
    regs[7] = 32'hFFFFFF23;
    step();
    inst_valid = 1'b1; inst = 32'h00171CA6; inst_pc = 32'h1C000008;
    ex_gr_we = 1'b1; ex_dest = 5'd5;
    step();
    inst_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("sll stall to_es", 32'(ds_to_es_valid), 32'd0);
      chk("sll stall allowin", 32'(ds_allowin), 32'd0);
      if (k < 2) step();
    end
    step();
    ex_gr_we = 1'b0;
    @(negedge clk);
    chk("sll valid", 32'(ds_to_es_valid), 32'd1);
    chk("sll op", 32'(es_alu_op), 32'h100);
    chk("sll src2", es_alu_src2, 32'h00000003);

    // xor held while EX refuses for 4 cycles; ori waits then loads
    regs[1] = 32'h0000F0F0; regs[2] = 32'h00FF00FF;
    step();
    inst_valid = 1'b1; inst = 32'h00158823; inst_pc = 32'h1C000010;
    step();
    es_allowin = 1'b0; inst = 32'h03AAF024; inst_pc = 32'h1C000014;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp pc", es_pc, 32'h1C000010);
      chk("bp op", 32'(es_alu_op), 32'h080);
      chk("bp allowin", 32'(ds_allowin), 32'd0);
      step();
    end
    es_allowin = 1'b1;
    @(negedge clk);
    chk("bp release pc", es_pc, 32'h1C000010);
    step();
    inst_valid = 1'b0;
    @(negedge clk);
    chk("ori pc", es_pc, 32'h1C000014);
    chk("ori op", 32'(es_alu_op), 32'h040);
    chk("ori src2", es_alu_src2, 32'h00000ABC);

    // Unknown word, then flush during a hazard stall
    step();
    inst_valid = 1'b1; inst = 32'hFFFFFFFF; inst_pc = 32'h1C000100;
    ex_gr_we = 1'b1; ex_dest = 5'd31;
    step();
    inst_valid = 1'b0;
    @(negedge clk);
    chk("bad invalid", 32'(es_inst_invalid), 32'd1);
    chk("bad op", 32'(es_alu_op), 32'd0);
    chk("bad we", 32'(es_gr_we), 32'd0);
    chk("bad valid", 32'(ds_to_es_valid), 32'd1);
    step();
    inst_valid = 1'b1; inst = 32'h00101CA2; inst_pc = 32'h1C000104; ex_dest = 5'd5;
    step();
    inst_valid = 1'b0;
    @(negedge clk);
    chk("haz to_es", 32'(ds_to_es_valid), 32'd0);
    chk("haz allowin", 32'(ds_allowin), 32'd0);
    step();
    flush = 1'b1; inst_valid = 1'b1; inst = 32'h02BFFCA4; inst_pc = 32'h1C000200;
    step();
    flush = 1'b0; inst_valid = 1'b0;
    @(negedge clk);
    chk("flush to_es", 32'(ds_to_es_valid), 32'd0);
    chk("flush allowin", 32'(ds_allowin), 32'd1);
    chk("flush pc", es_pc, 32'd0);
    ex_gr_we = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step();
      reset      = ($urandom_range(0, 99) < 2);
      flush      = ($urandom_range(0, 99) < 5);
      inst_valid = ($urandom_range(0, 99) < 80);
      inst       = gen_inst();
      inst_pc    = $urandom & 32'hFFFFFFFC;
      es_allowin = ($urandom_range(0, 99) < 75);
      ex_gr_we   = 1'($urandom_range(0, 1));
      ex_dest    = 5'($urandom_range(0, 7));
      mem_gr_we  = 1'($urandom_range(0, 1));
      mem_dest   = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(1, 7)] = $urandom;
    end
    step();
    reset = 1'b0; flush = 1'b0; inst_valid = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
